nbin_seq: RTL
=============

NBIN_SEQ -- requirements
Module: nbin_seq

Interface
REQ-001 Parameters SHALL be: TN, default 16, lane count; ADDR_SZ, default 6, RF address width; NUM_WORDS, default 64, words per lane; HALF = NUM_WORDS/2, the words per ping-pong half.
REQ-002 clk  in  1  sole clock; every register updates on posedge clk.
REQ-003 rst  in  1  reset, asynchronous, active-high.
REQ-004 i_wr_valid  in  TN  per-lane producer has a neuron/offset word to write.
REQ-005 o_wr_ready  out  TN  per-lane write accepted this cycle when valid&ready.
REQ-006 i_fill_done  in  1  single-cycle pulse closing the current fill half.
REQ-007 i_rd_en  in  1  consumer permits one drain step this cycle.
REQ-008 o_nb_wen  out  TN  NBin RF write enable, active-low.
REQ-009 o_addr  out  TN*ADDR_SZ  per-lane NBin RF address, shared by read and write.
REQ-010 o_off_wen  out  TN  offset store write enable, active-high.
REQ-011 o_off_wr_addr, o_off_rd_addr  out  TN*ADDR_SZ each  per-lane offset store addresses.
REQ-012 o_rd_valid  out  1  registered; RF/offset read data valid this cycle.
REQ-013 o_rd_lane_mask  out  TN  registered; lanes whose read data is meaningful.
REQ-014 o_rd_last  out  1  registered; final beat of a half.
REQ-015 o_half_full  out  2  per-half full flag.

Function
REQ-016 Storage SHALL be split into half 0 (addr 0..HALF-1) and half 1 (HALF..NUM_WORDS-1); address = {half bit, 5-bit index}.
REQ-017 State SHALL be: fill pointer fh, drain pointer dh, half_full[1:0], per-lane wr_cnt (0..HALF), per-half per-lane stored count cnt[h][i], and drain index rd_idx.
REQ-018 Drain step active (rd_act) SHALL be half_full[dh] && i_rd_en; lane i reads (rd_i) when rd_act && rd_idx < cnt[dh][i].
REQ-019 o_wr_ready[i] SHALL be !half_full[fh] && wr_cnt[i] < HALF && !rd_i (read has priority on the single-port RF).
REQ-020 On write accept lane i: o_nb_wen[i]=0, o_off_wen[i]=1, o_addr[i]=o_off_wr_addr[i]={fh, wr_cnt[i]}; wr_cnt[i] increments at the next edge.
REQ-021 On rd_i: o_addr[i]=o_off_rd_addr[i]={dh, rd_idx}, o_nb_wen[i]=1; otherwise, with no write, o_addr[i] SHALL be 0.
REQ-022 i_fill_done with !half_full[fh] SHALL copy wr_cnt (including a same-cycle accept) into cnt[fh], set half_full[fh], toggle fh, and clear all wr_cnt.
REQ-023 i_fill_done while half_full[fh] SHALL be ignored.
REQ-024 Drain length M SHALL be the maximum over lanes of cnt[dh][i]; each rd_act cycle increments rd_idx.
REQ-025 The rd_act cycle with rd_idx == M-1 is the last step; when M==0, the first rd_act cycle is the last step.
REQ-026 On the last step: clear half_full[dh], toggle dh, zero rd_idx.
REQ-027 One cycle after each rd_act (read latency 1): o_rd_valid=1, o_rd_lane_mask = the rd_i vector, o_rd_last = that step was last; M==0 yields one beat with mask 0 and last=1.
REQ-028 With i_rd_en low, state SHALL hold and o_rd_valid SHALL be 0.
REQ-029 A same-cycle last drain step of dh and i_fill_done on fh (fh!=dh) SHALL both take effect.
REQ-030 Writes and a drain of different halves SHALL proceed concurrently, except per-lane RF conflicts per REQ-019.

Reset
REQ-031 rst SHALL clear fh, dh, half_full, all wr_cnt, cnt and rd_idx to 0.
REQ-032 During rst: o_nb_wen all 1, o_off_wen 0, all addresses 0, o_wr_ready 0, o_rd_valid/o_rd_last/o_rd_lane_mask 0, o_half_full 0.
REQ-033 Reset mid-fill or mid-drain SHALL discard buffered contents with no further read beats.

Verification
REQ-034 Write 3 words to lane 0 and 5 to lane 1, then fill_done, then i_rd_en held -> 5 beats with masks 0x0003 x3 then 0x0002 x2; last on beat 5; addresses 0..4; half 0 released.
REQ-035 Write 32 words to lane 2 -> o_wr_ready[2] drops after the 32nd; a 33rd valid is not written (o_nb_wen[2] stays 1).
REQ-036 Fill half 0, fill half 1, then fill_done again -> third pulse ignored; o_wr_ready all 0 until half 0 drains.
REQ-037 Drain half 0 while lane 0 writes into half 1 -> on lane-0 read cycles o_wr_ready[0]=0, addr={0,idx}; otherwise addr={1,wr_cnt}; no lost or duplicated words.
REQ-038 fill_done with all counts 0, then i_rd_en -> one beat: o_rd_valid=1, mask 0, o_rd_last=1.
REQ-039 Assert rst during a drain at rd_idx=2 -> outputs at reset values immediately; no o_rd_valid after release; o_half_full=00.

Source files
------------

// File: rtl/nbin_seq.sv
// Ping-pong NBin RF/offset-store sequencer: per-lane fill into one half while the other half drains.
// Read beats follow each drain step by one cycle; reads win the single-port RF, so a reading lane is not write-ready.
module nbin_seq #(
  parameter int TN        = 16,
  parameter int ADDR_SZ   = 6,
  parameter int NUM_WORDS = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [TN-1:0]         i_wr_valid,
  output logic [TN-1:0]         o_wr_ready,
  input  logic                  i_fill_done,
  input  logic                  i_rd_en,
  output logic [TN-1:0]         o_nb_wen,
  output logic [TN*ADDR_SZ-1:0] o_addr,
  output logic [TN-1:0]         o_off_wen,
  output logic [TN*ADDR_SZ-1:0] o_off_wr_addr,
  output logic [TN*ADDR_SZ-1:0] o_off_rd_addr,
  output logic                  o_rd_valid,
  output logic [TN-1:0]         o_rd_lane_mask,
  output logic                  o_rd_last,
  output logic [1:0]            o_half_full
);

  localparam int HALF = NUM_WORDS / 2;
  localparam int IW   = ADDR_SZ - 1;
  localparam int CW   = IW + 1;
  localparam logic [CW-1:0] HALF_C = CW'(HALF);
  localparam logic [CW-1:0] ONE_C  = CW'(1);

  logic                          fh_q, fh_d;
  logic                          dh_q, dh_d;
  logic [1:0]                    half_full_q, half_full_d;
  logic [TN-1:0][CW-1:0]         wr_cnt_q, wr_cnt_d;
  logic [1:0][TN-1:0][CW-1:0]    cnt_q, cnt_d;
  logic [CW-1:0]                 rd_idx_q, rd_idx_d;
  logic                          rd_valid_q;
  logic [TN-1:0]                 rd_mask_q;
  logic                          rd_last_q;

  logic                          rd_act;
  logic                          last_step;
  logic                          fill_ok;
  logic [CW-1:0]                 m_len;
  logic [TN-1:0]                 rd_lane;
  logic [TN-1:0]                 wr_rdy;
  logic [TN-1:0]                 wr_acc;
  logic [TN-1:0][ADDR_SZ-1:0]    wr_addr;
  logic [TN-1:0][ADDR_SZ-1:0]    rd_addr;
  logic [TN-1:0][ADDR_SZ-1:0]    addr;

  // Drain length is the longest lane of the draining half; a zero-length half still takes one step.
  always_comb begin
    rd_act = half_full_q[dh_q] && i_rd_en;
    m_len  = '0;
    for (int i = 0; i < TN; i++) begin
      if (cnt_q[dh_q][i] > m_len) m_len = cnt_q[dh_q][i];
    end
    last_step = rd_act && ((m_len == '0) || (rd_idx_q == (m_len - ONE_C)));
    fill_ok   = i_fill_done && !half_full_q[fh_q];
  end

  always_comb begin
    rd_lane = '0;
    wr_rdy  = '0;
    wr_acc  = '0;
    wr_addr = '0;
    rd_addr = '0;
    addr    = '0;
    for (int i = 0; i < TN; i++) begin
      rd_lane[i] = rd_act && (rd_idx_q < cnt_q[dh_q][i]);
      wr_rdy[i]  = !rst && !half_full_q[fh_q] && (wr_cnt_q[i] < HALF_C) && !rd_lane[i];
      wr_acc[i]  = i_wr_valid[i] && wr_rdy[i];
      if (wr_acc[i]) wr_addr[i] = {fh_q, wr_cnt_q[i][IW-1:0]};
      if (rd_lane[i]) rd_addr[i] = {dh_q, rd_idx_q[IW-1:0]};
      addr[i] = wr_addr[i] | rd_addr[i];
    end
  end

  always_comb begin
    fh_d        = fh_q;
    dh_d        = dh_q;
    half_full_d = half_full_q;
    cnt_d       = cnt_q;
    rd_idx_d    = rd_idx_q;
    wr_cnt_d    = wr_cnt_q;
    for (int i = 0; i < TN; i++) begin
      wr_cnt_d[i] = wr_cnt_q[i] + {{(CW-1){1'b0}}, wr_acc[i]};
    end
    // Closing a half snapshots counts including this cycle's accepts.
    if (fill_ok) begin
      cnt_d[fh_q]       = wr_cnt_d;
      half_full_d[fh_q] = 1'b1;
      fh_d              = ~fh_q;
      wr_cnt_d          = '0;
    end
    if (last_step) begin
      half_full_d[dh_q] = 1'b0;
      dh_d              = ~dh_q;
      rd_idx_d          = '0;
    end else if (rd_act) begin
      rd_idx_d = rd_idx_q + ONE_C;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fh_q        <= 1'b0;
      dh_q        <= 1'b0;
      half_full_q <= '0;
      wr_cnt_q    <= '0;
      cnt_q       <= '0;
      rd_idx_q    <= '0;
      rd_valid_q  <= 1'b0;
      rd_mask_q   <= '0;
      rd_last_q   <= 1'b0;
    end else begin
      fh_q        <= fh_d;
      dh_q        <= dh_d;
      half_full_q <= half_full_d;
      wr_cnt_q    <= wr_cnt_d;
      cnt_q       <= cnt_d;
      rd_idx_q    <= rd_idx_d;
      rd_valid_q  <= rd_act;
      rd_mask_q   <= rd_lane;
      rd_last_q   <= last_step;
    end
  end

  assign o_wr_ready     = wr_rdy;
  assign o_nb_wen       = ~wr_acc;
  assign o_off_wen      = wr_acc;
  assign o_addr         = addr;
  assign o_off_wr_addr  = wr_addr;
  assign o_off_rd_addr  = rd_addr;
  assign o_rd_valid     = rd_valid_q;
  assign o_rd_lane_mask = rd_mask_q;
  assign o_rd_last      = rd_last_q;
  assign o_half_full    = half_full_q;

endmodule
